seq_detect_sched: RTL and testbench

SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

---
 rtl/seq_detect_sched_pkg.sv | 17 +
 rtl/seq_detect_sched_rr_arbiter.sv | 33 +++
 rtl/seq_detect_sched.sv | 156 +++++++++++++++
 tb/tb_seq_detect_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_sched_pkg.sv
// seq_detect_sched_pkg: engine state encoding and default parameter values
// shared by the round-robin serial run detector and its arbiter.
package seq_detect_sched_pkg;

  // Engine states: wait for a request, count a run, flag it, drop the grant.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    DETECT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int NREQ_DEF   = 4;   // requesting serial channels
  localparam int CNT_W_DEF  = 4;   // run counter / cfg_len width
  localparam int WINDOW_DEF = 15;  // COUNT cycles allowed per grant (<= 255)

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. The search starts at ptr and
// wraps modulo NREQ; the first requesting channel found wins.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         sel,
  output logic [$clog2(NREQ)-1:0] index,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // Walk the channels from ptr upward, keeping only the first hit.
  always_comb begin
    sel   = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        sel[cand] = 1'b1;
        index     = cand;
      end
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: grants one serial channel at a time (round-robin) and
// watches its data bit for a run of cfg_len consecutive 1s, pulsing z when
// the run completes. Optional macro SEQ_DETECT_SCHED_TIMEOUT_EN adds a
// per-grant window limit of WINDOW COUNT cycles, reported on tout.
module seq_detect_sched
  import seq_detect_sched_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         w,
  input  logic [CNT_W-1:0]        cfg_len,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    z,
  output logic [$clog2(NREQ)-1:0] z_ch,
  output logic                    tout
);

  localparam int IW = $clog2(NREQ);

  state_t            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [IW-1:0]     ch_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     z_ch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  len_q;
  logic              busy_q;
  logic              z_q;

  logic [NREQ-1:0]   arb_sel;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

  logic [IW-1:0]     ptr_d;
  logic [CNT_W:0]    run_d;
  logic [CNT_W:0]    eff_len_d;
  logic              hit_d;
  logic              timeout_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .sel   (arb_sel),
    .index (arb_idx),
    .any   (arb_any)
  );

  // Next pointer sits just past the winner; a zero length acts as one.
  assign ptr_d     = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
  assign run_d     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign eff_len_d = (len_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, len_q};
  assign hit_d     = w[ch_q] && (run_d == eff_len_d);

`ifdef SEQ_DETECT_SCHED_TIMEOUT_EN
  logic [7:0] win_q;
  logic [8:0] win_d;
  logic       tout_q;

  assign win_d     = {1'b0, win_q} + 9'd1;
  assign timeout_d = (win_d >= 9'(WINDOW));

  // Window counter: zero outside COUNT, one tick per COUNT cycle; tout marks
  // the RELEASE cycle entered because the window ran out without a run.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      win_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      win_q  <= (state_q == COUNT) ? win_d[7:0] : '0;
      tout_q <= (state_q == COUNT) && req[ch_q] && !hit_d && timeout_d;
    end
  end

  assign tout = tout_q;
`else
  // WINDOW only shapes the timeout path; keep it referenced in this build.
  logic unused_window;
  assign unused_window = (WINDOW > 255);
  assign timeout_d     = 1'b0;
  assign tout          = 1'b0;
`endif

  // Engine FSM with all outputs registered alongside the state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      z_ch_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q <= COUNT;
            gnt_q   <= arb_sel;
            ch_q    <= arb_idx;
            ptr_q   <= ptr_d;
            len_q   <= cfg_len;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          // Request drop wins over data; a completed run wins over timeout.
          if (!req[ch_q]) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
          end else if (hit_d) begin
            state_q <= DETECT;
            z_q     <= 1'b1;
            z_ch_q  <= ch_q;
          end else if (timeout_d) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
          end else if (w[ch_q]) begin
            cnt_q   <= run_d[CNT_W-1:0];
          end else begin
            cnt_q   <= '0;
          end
        end
        DETECT: begin
          state_q <= RELEASE;
          gnt_q   <= '0;
          z_q     <= 1'b0;
        end
        RELEASE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          z_q     <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign z    = z_q;
  assign z_ch = z_ch_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: directed scenarios followed by biased random traffic,
// every cycle compared against a transaction-level model of the grant rules.
module tb_seq_detect_sched;

  localparam int NREQ   = 4;
  localparam int CNT_W  = 4;
  localparam int WINDOW = 4;
`ifdef SEQ_DETECT_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             Clock = 1'b0;
  logic             Resetn;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  w;
  logic [CNT_W-1:0] cfg_len;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             z;
  logic [1:0]       z_ch;
  logic             tout;

  seq_detect_sched #(.NREQ(NREQ), .CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .req     (req),
    .w       (w),
    .cfg_len (cfg_len),
    .gnt     (gnt),
    .busy    (busy),
    .z       (z),
    .z_ch    (z_ch),
    .tout    (tout)
  );

  always #5 Clock = ~Clock;

  int    n_cmp = 0;
  int    n_bad = 0;
  string phase = "init";

  // Reference model: who owns the engine, how long the current run is,
  // and which one-cycle after-effects (detect flag, release gap) are showing.
  int m_owner;    // granted channel, -1 when nothing is granted
  int m_ptr;      // where the next round-robin search begins
  int m_run;      // consecutive 1s seen on the owner's data bit
  int m_need;     // run length latched at grant time
  int m_elapsed;  // data samples taken during this grant
  int m_zch;      // channel reported with the last detection
  bit m_z;        // detection pulse showing this cycle
  bit m_cool;     // mandatory empty cycle after a grant
  bit m_tout;     // that empty cycle was caused by the window running out

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_run = 0; m_need = 1; m_elapsed = 0;
    m_zch = 0; m_z = 1'b0; m_cool = 1'b0; m_tout = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs about to be sampled.
  function automatic void model_step();
    logic [1:0] oi;
    bit found;
    int pick;
    if (m_cool) begin
      m_cool = 1'b0;
      m_tout = 1'b0;
    end else if (m_z) begin
      m_z     = 1'b0;
      m_owner = -1;
      m_cool  = 1'b1;
    end else if (m_owner >= 0) begin
      oi = 2'(m_owner);
      if (!req[oi]) begin
        m_owner = -1;
        m_cool  = 1'b1;
      end else begin
        m_elapsed++;
        m_run = w[oi] ? m_run + 1 : 0;
        if (m_run >= m_need) begin
          m_z   = 1'b1;
          m_zch = m_owner;
        end else if (TO_EN && m_elapsed >= WINDOW) begin
          m_owner = -1;
          m_cool  = 1'b1;
          m_tout  = 1'b1;
        end
      end
    end else begin
      found = 1'b0;
      pick  = 0;
      for (int k = 0; k < NREQ; k++) begin
        oi = 2'((m_ptr + k) % NREQ);
        if (!found && req[oi]) begin
          found = 1'b1;
          pick  = int'(oi);
        end
      end
      if (found) begin
        m_owner   = pick;
        m_ptr     = (pick + 1) % NREQ;
        m_need    = (cfg_len == '0) ? 1 : int'(cfg_len);
        m_run     = 0;
        m_elapsed = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[2'(m_owner)] = 1'b1;
    check("gnt",  8'(gnt),  8'(eg));
    check("busy", 8'(busy), 8'((m_owner >= 0) || m_cool));
    check("z",    8'(z),    8'(m_z));
    check("z_ch", 8'(z_ch), 8'(m_zch));
    check("tout", 8'(tout), 8'(m_tout));
  endtask

  // One clock: drive at the falling edge, let the rising edge act, check at
  // the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] wv, input logic [3:0] cl);
    req = r; w = wv; cfg_len = cl;
    model_step();
    @(posedge Clock);
    @(negedge Clock);
    check_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic async_reset();
    Resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge Clock);
    check_all();
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b0; req = '0; w = '0; cfg_len = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    phase = "reset";
    check_all();
    Resetn = 1'b1;

    phase = "idle";
    cyc(4'b0000, 4'b0000, 4'd0);
    cyc(4'b0000, 4'b1111, 4'd3);

    // Single channel, length 3, data 1,1,0,1,1,1.
    phase = "single";
    cyc(4'b0001, 4'b0000, 4'd3);
    cyc(4'b0001, 4'b0001, 4'd3);
    cyc(4'b0001, 4'b0001, 4'd3);
    cyc(4'b0001, 4'b0000, 4'd3);
    cyc(4'b0001, 4'b0001, 4'd3);
    cyc(4'b0001, 4'b0001, 4'd3);
    cyc(4'b0001, 4'b0001, 4'd3);
    cyc(4'b0001, 4'b0000, 4'd3);
    cyc(4'b0000, 4'b0000, 4'd3);
    cyc(4'b0000, 4'b0000, 4'd3);

    // Fairness from a freshly reset pointer.
    phase = "fair";
    async_reset();
    for (int i = 0; i < 20; i++) cyc(4'b1111, 4'b1111, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);

    // Request drop on the edge that would complete the run.
    phase = "abort";
    cyc(4'b0100, 4'b0000, 4'd2);
    cyc(4'b0100, 4'b0100, 4'd2);
    cyc(4'b0000, 4'b0100, 4'd2);
    cyc(4'b0000, 4'b0000, 4'd2);
    cyc(4'b0000, 4'b0000, 4'd2);

    // Zero length acts as one.
    phase = "len0";
    cyc(4'b0001, 4'b0000, 4'd0);
    cyc(4'b0001, 4'b0001, 4'd5);
    cyc(4'b0000, 4'b0000, 4'd0);
    cyc(4'b0000, 4'b0000, 4'd0);

    // Length changed mid-grant and other channels requesting meanwhile.
    phase = "latch";
    cyc(4'b0010, 4'b0000, 4'd3);
    cyc(4'b1110, 4'b0010, 4'd1);
    cyc(4'b1110, 4'b0010, 4'd1);
    cyc(4'b0010, 4'b0010, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);

    // Data held low: timeout if enabled, otherwise the grant persists.
    phase = "window";
    cyc(4'b1000, 4'b0000, 4'd2);
    for (int i = 0; i < 10; i++) cyc(4'b1000, 4'b0000, 4'd2);
    cyc(4'b0000, 4'b0000, 4'd2);
    cyc(4'b0000, 4'b0000, 4'd2);
    cyc(4'b0000, 4'b0000, 4'd2);

    // Reset while channel 0 is counting; pointer must restart at 0.
    phase = "rst_mid";
    cyc(4'b0001, 4'b0000, 4'd3);
    cyc(4'b0001, 4'b0001, 4'd3);
    #2;
    async_reset();
    cyc(4'b1111, 4'b0000, 4'd1);
    cyc(4'b1111, 4'b0001, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);
    cyc(4'b0000, 4'b0000, 4'd1);

    // Biased random traffic: requests and data mostly high.
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom | $urandom), 4'($urandom | $urandom), 4'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
